// File: rtl/wb_write_queue.sv
// Four-entry write-back queue feeding a parallel-load register file through one-hot load enables.
// Optional WB_ZERO_DISCARD_EN: writes to register 0 complete the handshake but are never queued.
module wb_write_queue #(
  parameter  int N     = 32,
  parameter  int R     = 32,
  parameter  int DEPTH = 4,
  localparam int A     = (R > 1) ? $clog2(R) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [A-1:0] in_addr,
  input  logic [N-1:0] in_data,
  input  logic         stall,
  output logic [R-1:0] load,
  output logic [N-1:0] WriteData,
  output logic [2:0]   count,
  output logic         full,
  output logic         empty
);

  logic [A-1:0] addr_mem [DEPTH];
  logic [N-1:0] data_mem [DEPTH];

  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]   count_q, count_d;
  logic [R-1:0] load_q, load_d;
  logic [N-1:0] wdata_q, wdata_d;

  logic         push;
  logic         enq;
  logic         pop;
  logic [A-1:0] head_addr;
  logic [N-1:0] head_data;
  logic [R-1:0] head_onehot;

  assign full      = (count_q == 3'd4);
  assign empty     = (count_q == 3'd0);
  assign in_ready  = !full;
  assign count     = count_q;
  assign load      = load_q;
  assign WriteData = wdata_q;

  assign push = in_valid && in_ready;
`ifdef WB_ZERO_DISCARD_EN
  assign enq  = push && (in_addr != '0);
`else
  assign enq  = push;
`endif
  assign pop  = !empty && !stall;

  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  // Addresses at or beyond R match no decoder bit, so such writes pop with load = 0.
  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_dec
      assign head_onehot[gi] = (head_addr == A'(gi));
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    load_d   = '0;
    wdata_d  = wdata_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      load_d   = head_onehot;
      wdata_d  = head_data;
    end
    count_d = count_q + {2'b00, enq} - {2'b00, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      load_q   <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      load_q   <= load_d;
      wdata_q  <= wdata_d;
    end
  end

  // Entry storage carries no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_q] <= in_addr;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue with a load/data scoreboard checked whenever load pulses.
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        stall;
  logic [31:0] load;
  logic [31:0] WriteData;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  typedef struct {
    logic [31:0] ld;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wb_write_queue #(.N(32), .R(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .stall(stall), .load(load),
    .WriteData(WriteData), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input int a, input logic [31:0] d, input bit expect_out);
    exp_t e;
    in_valid = 1'b1;
    in_addr  = 5'(a);
    in_data  = d;
    if (expect_out) begin
      e.ld  = 32'd1 << a;
      e.dat = d;
      sb.push_back(e);
    end
    $display("push addr=%0d data=%08h queued_expect=%0d", a, d, expect_out);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && load !== 32'd0) begin
      exp_t e;
      chk("load_onehot", 64'($countones(load)), 64'd1);
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_load", 64'(load), 64'(e.ld));
        chk("sb_data", 64'(WriteData), 64'(e.dat));
        $display("pop load=%08h data=%08h", load, WriteData);
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; stall = 1'b0;
    repeat (2) tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_load", 64'(load), 64'd0);
    chk("rst_wdata", 64'(WriteData), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single write: minimum latency, one-cycle pulse, data held afterwards.
    drive_push(5, 32'hDEADBEEF, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_noload", 64'(load), 64'd0);
    tick();
    chk("t1_load", 64'(load), 64'h20);
    chk("t1_wdata", 64'(WriteData), 64'hDEADBEEF);
    chk("t1_count0", 64'(count), 64'd0);
    tick();
    chk("t1_loadoff", 64'(load), 64'd0);
    chk("t1_hold", 64'(WriteData), 64'hDEADBEEF);

    // Fill under stall, refused fifth push, then drain in order.
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_push(i, 32'h11 * i, 1'b1);
      tick();
    end
    drive_push(9, 32'h55, 1'b0);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("t2_count4", 64'(count), 64'd4);
    stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_load", 64'(load), 64'd1 << i);
      chk("t2_wdata", 64'(WriteData), 64'(32'h11 * i));
    end
    tick();
    chk("t2_empty", 64'(empty), 64'd1);
    chk("t2_loadoff", 64'(load), 64'd0);

    // Simultaneous push/pop at count 2, running across pointer wrap.
    stall = 1'b1;
    drive_push(6, 32'hA6, 1'b1);
    tick();
    drive_push(7, 32'hA7, 1'b1);
    tick();
    chk("t3_count2", 64'(count), 64'd2);
    stall = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      drive_push(8 + i, 32'h1000 + i, 1'b1);
      tick();
      chk("t3_count_steady", 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("t3_empty", 64'(empty), 64'd1);

    // Asynchronous reset mid-operation discards queued entries.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_push(20 + i, 32'hC0 + i, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    chk("t4_count3", 64'(count), 64'd3);
    #3 rst = 1'b0;
    #1;
    sb.delete();
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_empty", 64'(empty), 64'd1);
    chk("t4_full", 64'(full), 64'd0);
    chk("t4_ready", 64'(in_ready), 64'd1);
    chk("t4_load", 64'(load), 64'd0);
    chk("t4_wdata", 64'(WriteData), 64'd0);
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_noload", 64'(load), 64'd0);
    end
    chk("t4_count_after", 64'(count), 64'd0);

    // Address 0 write.
`ifdef WB_ZERO_DISCARD_EN
    drive_push(0, 32'h1234, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t5_count", 64'(count), 64'd0);
    tick();
    chk("t5_load", 64'(load), 64'd0);
    tick();
    chk("t5_load2", 64'(load), 64'd0);
`else
    drive_push(0, 32'h1234, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t5_count", 64'(count), 64'd1);
    tick();
    chk("t5_load", 64'(load), 64'd1);
    chk("t5_wdata", 64'(WriteData), 64'h1234);
    tick();
    chk("t5_loadoff", 64'(load), 64'd0);
`endif

    repeat (2) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
